// File: rtl/ycbcr_pkg.sv
// ---------------------------------------------------------------------------
// ycbcr_pkg
// Shared constants for the RGB-to-YCbCr coefficient controller:
//   - default coefficient widths (COEF_W_DEF, OFFS_W_DEF)
//   - coefficient address map (ADDR_M1..ADDR_M9, ADDR_V1..ADDR_V3)
//   - BT.601 full-range reset values for both register banks
//   - commit FSM state type
// ---------------------------------------------------------------------------
package ycbcr_pkg;

    localparam int COEF_W_DEF = 18;
    localparam int OFFS_W_DEF = 9;

    localparam logic [3:0] ADDR_M1 = 4'd0;
    localparam logic [3:0] ADDR_M2 = 4'd1;
    localparam logic [3:0] ADDR_M3 = 4'd2;
    localparam logic [3:0] ADDR_M4 = 4'd3;
    localparam logic [3:0] ADDR_M5 = 4'd4;
    localparam logic [3:0] ADDR_M6 = 4'd5;
    localparam logic [3:0] ADDR_M7 = 4'd6;
    localparam logic [3:0] ADDR_M8 = 4'd7;
    localparam logic [3:0] ADDR_M9 = 4'd8;
    localparam logic [3:0] ADDR_V1 = 4'd9;
    localparam logic [3:0] ADDR_V2 = 4'd10;
    localparam logic [3:0] ADDR_V3 = 4'd11;

    // BT.601 full-range matrix in signed Q2.16
    localparam int DEF_M1 = 32'sd19595;
    localparam int DEF_M2 = 32'sd38470;
    localparam int DEF_M3 = 32'sd7471;
    localparam int DEF_M4 = -32'sd11056;
    localparam int DEF_M5 = -32'sd21712;
    localparam int DEF_M6 = 32'sd32768;
    localparam int DEF_M7 = 32'sd32768;
    localparam int DEF_M8 = -32'sd27440;
    localparam int DEF_M9 = -32'sd5328;

    localparam int DEF_V1 = 32'sd0;
    localparam int DEF_V2 = 32'sd128;
    localparam int DEF_V3 = 32'sd128;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } cfg_state_e;

    // Reset value of matrix coefficient idx (0-based)
    function automatic int default_matrix(input int idx);
        case (idx)
            0:       return DEF_M1;
            1:       return DEF_M2;
            2:       return DEF_M3;
            3:       return DEF_M4;
            4:       return DEF_M5;
            5:       return DEF_M6;
            6:       return DEF_M7;
            7:       return DEF_M8;
            8:       return DEF_M9;
            default: return 32'sd0;
        endcase
    endfunction

    // Reset value of vector coefficient idx (0-based)
    function automatic int default_vector(input int idx);
        case (idx)
            0:       return DEF_V1;
            1:       return DEF_V2;
            2:       return DEF_V3;
            default: return 32'sd0;
        endcase
    endfunction

endpackage

// File: rtl/ycbcr_coef_ctrl_if.sv
// ---------------------------------------------------------------------------
// ycbcr_coef_ctrl_if
// Coefficient configuration port of ycbcr_coef_ctrl.
//   cfg_valid/cfg_ready/cfg_addr/cfg_data : write handshake into shadow bank
//   cfg_commit                            : request swap at next frame start
//   cfg_pending, cfg_err, applied         : status back to the host
// master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface ycbcr_coef_ctrl_if
    import ycbcr_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_addr;
    logic [COEF_W-1:0] cfg_data;
    logic              cfg_commit;
    logic              cfg_pending;
    logic              cfg_err;
    logic              applied;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, cfg_commit,
        input  cfg_ready, cfg_pending, cfg_err, applied
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
        output cfg_ready, cfg_pending, cfg_err, applied
    );
endinterface

// File: rtl/sync_delay.sv
// ---------------------------------------------------------------------------
// sync_delay
// LAT-deep shift register used to keep {hsync, vsync, de} aligned with the
// colour datapath.
//   clk, rst_n : clock, asynchronous active-low reset (line clears to 0)
//   din        : sync bundle in
//   dout       : sync bundle delayed by exactly LAT cycles
// ---------------------------------------------------------------------------
module sync_delay #(
    parameter int LAT = 3,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe_r [LAT];

    // Shift the sync bundle one stage per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[LAT-1];

endmodule

// File: rtl/ycbcr_coef_ctrl.sv
// ---------------------------------------------------------------------------
// ycbcr_coef_ctrl
// Double-buffered coefficient bank and sync alignment for the RGB-to-YCbCr
// datapath. Writes land in the shadow bank; a commit arms a swap that copies
// shadow -> active on the next rising edge of in_vsync, so a frame never
// mixes coefficient sets.
// Ports:
//   clk, rst_n           : pixel clock, asynchronous active-low reset
//   cfg                  : configuration interface (slave modport)
//   in_hsync/vsync/de    : input sync
//   matrix_coef          : 9 active matrix coefficients, coef1 at LSB
//   vector_coef          : 3 active offsets, vector_coef1 at LSB
//   out_hsync/vsync/de   : input sync delayed by LAT cycles
// Optional macro YCBCR_COEF_READBACK_EN adds rd_addr/rd_data: registered
// readback of the active bank (offsets zero-extended, illegal addresses 0).
// ---------------------------------------------------------------------------
module ycbcr_coef_ctrl
    import ycbcr_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int OFFS_W = OFFS_W_DEF,
    parameter int LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ycbcr_coef_ctrl_if.slave      cfg,
    input  logic                  in_hsync,
    input  logic                  in_vsync,
    input  logic                  in_de,
    output logic [9*COEF_W-1:0]   matrix_coef,
    output logic [3*OFFS_W-1:0]   vector_coef,
    output logic                  out_hsync,
    output logic                  out_vsync,
    output logic                  out_de
`ifdef YCBCR_COEF_READBACK_EN
    ,
    input  logic [3:0]            rd_addr,
    output logic [COEF_W-1:0]     rd_data
`endif
);

    cfg_state_e        state_r;
    cfg_state_e        next_state_s;
    logic              pending_r;
    logic              ready_r;
    logic              err_r;
    logic              applied_r;
    logic              vs_prev_r;
    logic              vs_rise_s;
    logic              wr_en_s;
    logic              swap_s;
    logic              illegal_s;
    logic [8:0]        wr_m_s;
    logic [2:0]        wr_v_s;

    logic [COEF_W-1:0] shadow_m_r [9];
    logic [COEF_W-1:0] active_m_r [9];
    logic [OFFS_W-1:0] shadow_v_r [3];
    logic [OFFS_W-1:0] active_v_r [3];

    // Write-address decode; only a completed handshake produces enables
    always_comb begin
        wr_en_s   = cfg.cfg_valid & ready_r;
        vs_rise_s = in_vsync & ~vs_prev_r;
        wr_m_s    = 9'd0;
        wr_v_s    = 3'd0;
        for (int i = 0; i < 9; i++) begin
            wr_m_s[i] = wr_en_s && (cfg.cfg_addr == (ADDR_M1 + 4'(i)));
        end
        for (int i = 0; i < 3; i++) begin
            wr_v_s[i] = wr_en_s && (cfg.cfg_addr == (ADDR_V1 + 4'(i)));
        end
        illegal_s = wr_en_s && (cfg.cfg_addr > ADDR_V3);
    end

    // Commit FSM next-state; a commit seen in IDLE never swaps on that edge
    always_comb begin
        next_state_s = state_r;
        swap_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg.cfg_commit) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (vs_rise_s) begin
                    next_state_s = ST_IDLE;
                    swap_s       = 1'b1;
                end else begin
                    next_state_s = ST_ARMED;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Commit FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered status outputs and vsync edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
            ready_r   <= 1'b1;
            err_r     <= 1'b0;
            applied_r <= 1'b0;
            vs_prev_r <= 1'b0;
        end else begin
            pending_r <= (next_state_s == ST_ARMED);
            ready_r   <= (next_state_s != ST_ARMED);
            err_r     <= err_r | illegal_s;
            applied_r <= swap_s;
            vs_prev_r <= in_vsync;
        end
    end

    // Shadow bank: host writes; offsets keep only the low OFFS_W data bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                shadow_m_r[i] <= COEF_W'(default_matrix(i));
            end
            for (int i = 0; i < 3; i++) begin
                shadow_v_r[i] <= OFFS_W'(default_vector(i));
            end
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (wr_m_s[i]) begin
                    shadow_m_r[i] <= cfg.cfg_data;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (wr_v_s[i]) begin
                    shadow_v_r[i] <= cfg.cfg_data[OFFS_W-1:0];
                end
            end
        end
    end

    // Active bank: whole-bank copy only at the armed frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                active_m_r[i] <= COEF_W'(default_matrix(i));
            end
            for (int i = 0; i < 3; i++) begin
                active_v_r[i] <= OFFS_W'(default_vector(i));
            end
        end else if (swap_s) begin
            for (int i = 0; i < 9; i++) begin
                active_m_r[i] <= shadow_m_r[i];
            end
            for (int i = 0; i < 3; i++) begin
                active_v_r[i] <= shadow_v_r[i];
            end
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_mat
        assign matrix_coef[g*COEF_W +: COEF_W] = active_m_r[g];
    end

    for (genvar g = 0; g < 3; g++) begin : g_vec
        assign vector_coef[g*OFFS_W +: OFFS_W] = active_v_r[g];
    end

    assign cfg.cfg_ready   = ready_r;
    assign cfg.cfg_pending = pending_r;
    assign cfg.cfg_err     = err_r;
    assign cfg.applied     = applied_r;

    sync_delay #(
        .LAT (LAT),
        .W   (3)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({in_hsync, in_vsync, in_de}),
        .dout  ({out_hsync, out_vsync, out_de})
    );

`ifdef YCBCR_COEF_READBACK_EN
    logic [COEF_W-1:0] rd_sel_s;
    logic [COEF_W-1:0] rd_data_r;

    // Readback mux over the active bank
    always_comb begin
        rd_sel_s = '0;
        case (rd_addr)
            ADDR_M1: rd_sel_s = active_m_r[0];
            ADDR_M2: rd_sel_s = active_m_r[1];
            ADDR_M3: rd_sel_s = active_m_r[2];
            ADDR_M4: rd_sel_s = active_m_r[3];
            ADDR_M5: rd_sel_s = active_m_r[4];
            ADDR_M6: rd_sel_s = active_m_r[5];
            ADDR_M7: rd_sel_s = active_m_r[6];
            ADDR_M8: rd_sel_s = active_m_r[7];
            ADDR_M9: rd_sel_s = active_m_r[8];
            ADDR_V1: rd_sel_s = {{(COEF_W-OFFS_W){1'b0}}, active_v_r[0]};
            ADDR_V2: rd_sel_s = {{(COEF_W-OFFS_W){1'b0}}, active_v_r[1]};
            ADDR_V3: rd_sel_s = {{(COEF_W-OFFS_W){1'b0}}, active_v_r[2]};
            default: rd_sel_s = '0;
        endcase
    end

    // One-cycle readback register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else begin
            rd_data_r <= rd_sel_s;
        end
    end

    assign rd_data = rd_data_r;
`endif

endmodule
